// File: rtl/opensync_transmit_pit_stamp.sv
// Purpose: overwrite the 8-byte dispatch_pit field of opensync m/s frames with the egress sync time.
// Latency: fixed 2 cycles for every byte, with write gaps preserved.
// Backpressure: none; the egress stream is never stalled, and frames need at least one idle cycle between them.
module opensync_transmit_pit_stamp #(
  parameter logic [31:0] P_TX_LATENCY = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tsn_or_tte,
  input  logic [31:0] iv_syn_clock_cycle,
  input  logic [63:0] iv_syn_clk,
  input  logic [7:0]  iv_data,
  input  logic        i_data_wr,
  output logic [7:0]  ov_data,
  output logic        o_data_wr,
  output logic        o_stamp_pulse,
  output logic [15:0] ov_stamp_cnt
);

  typedef enum logic [2:0] {
    WAIT_IDLE_S,
    IDLE_S,
    MATCH_S,
    STAMP_S,
    PASS_S
  } state_t;

  localparam logic [63:0] LAT64 = {32'd0, P_TX_LATENCY};

  state_t      state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        data_wr_prev_q, data_wr_prev_d;
  logic [63:0] tx_syn_clk_q, tx_syn_clk_d;
  logic [63:0] stamp_q, stamp_d;
  logic [23:0] hdr_q, hdr_d;
  logic        wr1_q, wr1_d;
  logic [7:0]  dat1_q, dat1_d;
  logic        pulse1_q, pulse1_d;
  logic        wr2_q, wr2_d;
  logic [7:0]  dat2_q, dat2_d;
  logic        pulse2_q, pulse2_d;
  logic [15:0] stamp_cnt_q, stamp_cnt_d;

  logic        sof;
  logic [63:0] stamp_sum;
  logic [63:0] cycle64;
  logic        wrap;
  logic [2:0]  stamp_sel;

  assign ov_data       = dat2_q;
  assign o_data_wr     = wr2_q;
  assign o_stamp_pulse = pulse2_q;
  assign ov_stamp_cnt  = stamp_cnt_q;

  // Frame boundary detection, byte position, SOF time latch and the stamp value (ready after byte 1)
  always_comb begin
    sof            = i_data_wr & ~data_wr_prev_q;
    data_wr_prev_d = i_data_wr;
    byte_cnt_d     = '0;
    if (i_data_wr) begin
      byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    end
    tx_syn_clk_d = sof ? iv_syn_clk : tx_syn_clk_q;
    stamp_sum    = tx_syn_clk_q + LAT64;
    cycle64      = {32'd0, iv_syn_clock_cycle};
    // TTE time lives in [0, cycle); the latency addition can cross one cycle boundary at most
    wrap         = ~i_tsn_or_tte && (iv_syn_clock_cycle != 32'd0) && (stamp_sum >= cycle64);
    stamp_d      = stamp_q;
    if (i_data_wr && (byte_cnt_q == 11'd1)) begin
      stamp_d = wrap ? (stamp_sum - cycle64) : stamp_sum;
    end
  end

  // Frame classification FSM, stage-1 byte substitution and stamp accounting
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    stamp_cnt_d = stamp_cnt_q;
    wr1_d       = i_data_wr;
    dat1_d      = iv_data;
    pulse1_d    = 1'b0;
    stamp_sel   = 3'd7 - byte_cnt_q[2:0];
    unique case (state_q)
      // A frame already running when reset released is never classified
      WAIT_IDLE_S: begin
        if (!i_data_wr) state_d = IDLE_S;
      end
      IDLE_S: begin
        if (sof) state_d = MATCH_S;
      end
      MATCH_S: begin
        if (!i_data_wr) begin
          state_d = IDLE_S;
        end else begin
          unique case (byte_cnt_q)
            11'd12: hdr_d[23:16] = iv_data;
            11'd13: hdr_d[15:8]  = iv_data;
            11'd14: hdr_d[7:0]   = iv_data;
            11'd15: begin
              if ((hdr_q == 24'hFF_01_06) && (iv_data == 8'h03)) state_d = STAMP_S;
              else                                                state_d = PASS_S;
            end
            default: ;
          endcase
        end
      end
      STAMP_S: begin
        if (!i_data_wr) begin
          state_d = IDLE_S;
        end else if (byte_cnt_q >= 11'd16 && byte_cnt_q <= 11'd23) begin
          dat1_d = stamp_q[{stamp_sel, 3'b000} +: 8];
          if (byte_cnt_q == 11'd23) begin
            state_d     = PASS_S;
            stamp_cnt_d = stamp_cnt_q + 16'd1;
            pulse1_d    = 1'b1;
          end
        end
      end
      PASS_S: begin
        if (!i_data_wr) state_d = IDLE_S;
      end
      default: state_d = WAIT_IDLE_S;
    endcase
  end

  // Second pipeline stage simply follows the first
  always_comb begin
    wr2_d    = wr1_q;
    dat2_d   = dat1_q;
    pulse2_d = pulse1_q;
  end

  // State and pipeline registers, all cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= WAIT_IDLE_S;
      byte_cnt_q     <= '0;
      data_wr_prev_q <= 1'b0;
      tx_syn_clk_q   <= '0;
      stamp_q        <= '0;
      hdr_q          <= '0;
      wr1_q          <= 1'b0;
      dat1_q         <= '0;
      pulse1_q       <= 1'b0;
      wr2_q          <= 1'b0;
      dat2_q         <= '0;
      pulse2_q       <= 1'b0;
      stamp_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      data_wr_prev_q <= data_wr_prev_d;
      tx_syn_clk_q   <= tx_syn_clk_d;
      stamp_q        <= stamp_d;
      hdr_q          <= hdr_d;
      wr1_q          <= wr1_d;
      dat1_q         <= dat1_d;
      pulse1_q       <= pulse1_d;
      wr2_q          <= wr2_d;
      dat2_q         <= dat2_d;
      pulse2_q       <= pulse2_d;
      stamp_cnt_q    <= stamp_cnt_d;
    end
  end

endmodule
